// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the note sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_FIN
    } state_t;

    localparam int REST_BIT = 11;
    localparam int STR_MSB  = 10;
    localparam int STR_LSB  = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    localparam logic [2:0] STR_A_HIGH = 3'd0;
    localparam logic [2:0] STR_E_HIGH = 3'd1;
    localparam logic [2:0] STR_B      = 3'd2;
    localparam logic [2:0] STR_G      = 3'd3;
    localparam logic [2:0] STR_D      = 3'd4;
    localparam logic [2:0] STR_A      = 3'd5;
    localparam logic [2:0] STR_E_LOW  = 3'd6;
    localparam logic [2:0] STR_B_LOW  = 3'd7;

    function automatic logic [7:0] string_onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - TICK_DIV prescaler with clear and enable, one-cycle tick pulse
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - 16-entry melody sequencer gating string tones to audio_out
// Optional SEQ_LOOP_EN adds a loop input that restarts the table at the last GAP exit.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV  = 1_000_000,
    parameter int GAP_TICKS = 2,
    parameter int DEPTH     = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic [4:0]  len,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  tones,
`ifdef SEQ_LOOP_EN
    input  logic        loop,
`endif
    output logic        busy,
    output logic [7:0]  note_sel,
    output logic        audio_out,
    output logic [3:0]  step_idx,
    output logic        done
);

    localparam logic [4:0] LEN_MAX  = 5'(DEPTH);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    logic [11:0] table_q [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  dur_q, dur_d;
    logic [7:0]  dcnt_q, dcnt_d;
    logic [7:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        audio_q, audio_d;
    logic        done_q, done_d;

    logic        tick, tick_clr, tick_en;
    logic        is_last, exit_now, wrap;
    logic [11:0] entry;

`ifdef SEQ_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    assign tick_clr = (state_q != S_PLAY) && (state_q != S_GAP);
    assign tick_en  = !tick_clr;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    assign entry   = table_q[step_q];
    assign is_last = ({1'b0, step_q} == (len_q - 5'd1));

    always_ff @(posedge CLK) begin
        if (wr_en && !busy_q) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        len_d    = len_q;
        dur_d    = dur_q;
        dcnt_d   = dcnt_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        audio_d  = |(sel_q & tones);
        exit_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                    step_d  = 4'd0;
                    busy_d  = 1'b1;
                    state_d = (len == 5'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                dur_d  = entry[DUR_MSB:DUR_LSB];
                dcnt_d = 8'd0;
                if (entry[DUR_MSB:DUR_LSB] == 8'd0) begin
                    if (is_last) begin
                        state_d = S_FIN;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end else begin
                    sel_d   = entry[REST_BIT] ? 8'd0 : string_onehot(entry[STR_MSB:STR_LSB]);
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (dcnt_q == dur_q - 8'd1) begin
                        sel_d  = 8'd0;
                        dcnt_d = 8'd0;
                        if (GAP_TICKS == 0) begin
                            exit_now = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (dcnt_q == GAP_LAST) begin
                        exit_now = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared end-of-entry decision, reached from GAP or directly from PLAY when there is no gap
        if (exit_now) begin
            if (!is_last) begin
                step_d  = step_q + 4'd1;
                state_d = S_FETCH;
            end else if (wrap) begin
                step_d  = 4'd0;
                state_d = S_FETCH;
            end else begin
                state_d = S_FIN;
            end
        end

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            step_d  = 4'd0;
            sel_d   = 8'd0;
            busy_d  = 1'b0;
            audio_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            len_q   <= 5'd0;
            dur_q   <= 8'd0;
            dcnt_q  <= 8'd0;
            sel_q   <= 8'd0;
            busy_q  <= 1'b0;
            audio_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            dur_q   <= dur_d;
            dcnt_q  <= dcnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            audio_q <= audio_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign note_sel  = sel_q;
    assign audio_out = audio_q;
    assign step_idx  = step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench, GAP_TICKS=0 and GAP_TICKS=2 instances
module tb_note_sequencer;

    logic        CLK, RST, wr_en, start, stop;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [4:0]  len;
    logic [7:0]  tones;
`ifdef SEQ_LOOP_EN
    logic        loop_in;
`endif

    logic       busy0, audio0, done0, busy2, audio2, done2;
    logic [7:0] sel0, sel2;
    logic [3:0] step0, step2;

    int checks = 0;
    int passed = 0;
    int done_idx, done_cnt, amis;
    logic [7:0] sel_log [64];
    logic [3:0] stp_log [64];
    logic       busy_log [64];

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(0)) dut0 (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .tones(tones),
`ifdef SEQ_LOOP_EN
        .loop(loop_in),
`endif
        .busy(busy0), .note_sel(sel0), .audio_out(audio0), .step_idx(step0), .done(done0)
    );

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(2)) dut2 (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .tones(tones),
`ifdef SEQ_LOOP_EN
        .loop(loop_in),
`endif
        .busy(busy2), .note_sel(sel2), .audio_out(audio2), .step_idx(step2), .done(done2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy2) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", {31'd0, busy0 | busy2}, 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic kick(input logic [4:0] l);
        @(negedge CLK);
        len = l; start = 1'b1;
    endtask

    // Logs one DUT per cycle starting at the first negedge after start is sampled
    task automatic monitor(input int which, input int budget);
        logic [7:0] s, prev_s, prev_t;
        logic a, d;
        done_idx = -1; done_cnt = 0; amis = 0; prev_s = 8'd0; prev_t = tones;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            start = 1'b0;
            s = (which != 0) ? sel2 : sel0;
            a = (which != 0) ? audio2 : audio0;
            d = (which != 0) ? done2 : done0;
            sel_log[i]  = s;
            stp_log[i]  = (which != 0) ? step2 : step0;
            busy_log[i] = (which != 0) ? busy2 : busy0;
            if (a !== |(prev_s & prev_t)) amis++;
            if (d) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            prev_s = s;
            tones = {tones[6:0], tones[7] ^ tones[5] ^ tones[4] ^ tones[3]};
            prev_t = tones;
        end
    endtask

    function automatic int count_val(input int budget, input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < budget; i++) if (sel_log[i] == v) c++;
        return c;
    endfunction

    function automatic int count_nz(input int budget);
        int c = 0;
        for (int i = 0; i < budget; i++) if (sel_log[i] != 8'd0) c++;
        return c;
    endfunction

    function automatic int first_idx(input int budget, input logic [7:0] v);
        for (int i = 0; i < budget; i++) if (sel_log[i] == v) return i;
        return -1;
    endfunction

    initial begin
        int dc;
        RST = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 12'd0;
        len = 5'd0; start = 1'b0; stop = 1'b0; tones = 8'hA5;
`ifdef SEQ_LOOP_EN
        loop_in = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_note_sel", {24'd0, sel2}, 32'd0);
        chk("rst_misc", {26'd0, audio2, done2, step2}, 32'd0);

        // single note on string 2 for 3 ticks, no gap
        wr(4'd0, 12'h203);
        kick(5'd1);
        monitor(0, 20);
        chk("t1_first_on", first_idx(20, 8'h04), 1);
        chk("t1_on_cycles", count_val(20, 8'h04), 12);
        chk("t1_nonzero", count_nz(20), 12);
        chk("t1_done_idx", done_idx, 14);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_fin", {31'd0, busy_log[13]}, 1);
        chk("t1_busy_done", {31'd0, busy_log[14]}, 0);
        chk("t1_audio", amis, 0);
        wait_idle();

        // three entries with gap, middle one a rest
        wr(4'd0, 12'h501);
        wr(4'd1, 12'hB02);
        wr(4'd2, 12'h001);
        kick(5'd3);
        monitor(1, 50);
        chk("t2_first_a", first_idx(50, 8'h20), 1);
        chk("t2_cnt_a", count_val(50, 8'h20), 4);
        chk("t2_first_c", first_idx(50, 8'h01), 31);
        chk("t2_cnt_c", count_val(50, 8'h01), 4);
        chk("t2_nonzero", count_nz(50), 8);
        chk("t2_step12", stp_log[12], 0);
        chk("t2_step13", stp_log[13], 1);
        chk("t2_step30", stp_log[30], 2);
        chk("t2_done_idx", done_idx, 44);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_audio", amis, 0);
        wait_idle();

        // len = 0
        kick(5'd0);
        monitor(1, 6);
        chk("z_done_idx", done_idx, 1);
        chk("z_done_cnt", done_cnt, 1);
        chk("z_nonzero", count_nz(6), 0);
        wait_idle();

        // zero-duration entry is skipped
        wr(4'd0, 12'h100);
        wr(4'd1, 12'h401);
        kick(5'd2);
        monitor(1, 20);
        chk("d0_first_on", first_idx(20, 8'h10), 2);
        chk("d0_cnt", count_val(20, 8'h10), 4);
        chk("d0_step1", stp_log[1], 1);
        chk("d0_done_idx", done_idx, 15);
        wait_idle();

        // stop during PLAY of entry 1
        kick(5'd2);
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("ab_playing", {24'd0, sel2}, 32'h10);
        stop = 1'b1; tones = 8'hFF;
        @(negedge CLK);
        stop = 1'b0;
        chk("ab_busy", {31'd0, busy2}, 0);
        chk("ab_sel", {24'd0, sel2}, 0);
        chk("ab_audio", {31'd0, audio2}, 0);
        dc = 0;
        repeat (20) begin
            @(negedge CLK);
            if (done2) dc++;
        end
        chk("ab_no_done", dc, 0);
        wait_idle();

        // start and stop together from IDLE
        @(negedge CLK);
        len = 5'd2; start = 1'b1; stop = 1'b1;
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
        chk("col_busy", {31'd0, busy2}, 0);
        repeat (5) @(negedge CLK);
        chk("col_idle", {23'd0, busy2, sel2}, 0);

        // write while busy is ignored
        kick(5'd2);
        @(negedge CLK); start = 1'b0;
        wr(4'd0, 12'h602);
        wait_idle();
        kick(5'd2);
        monitor(1, 20);
        chk("wp_no_new", count_val(20, 8'h40), 0);
        chk("wp_old_first", first_idx(20, 8'h10), 2);
        wait_idle();

        // async reset in GAP
        kick(5'd2);
        @(negedge CLK); start = 1'b0;
        repeat (8) @(negedge CLK);
        chk("rs_busy_pre", {31'd0, busy2}, 1);
        RST = 1'b1;
        #2;
        chk("rs_outputs", {17'd0, busy2, sel2, audio2, step2, done2}, 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_idle();

`ifdef SEQ_LOOP_EN
        wr(4'd0, 12'h401);
        wr(4'd1, 12'h101);
        loop_in = 1'b1;
        kick(5'd2);
        fork
            monitor(1, 60);
            begin
                repeat (46) @(negedge CLK);
                loop_in = 1'b0;
            end
        join
        chk("lp_step13", stp_log[13], 1);
        chk("lp_step26", stp_log[26], 0);
        chk("lp_step39", stp_log[39], 1);
        chk("lp_cnt_a", count_val(60, 8'h10), 8);
        chk("lp_first_b", first_idx(60, 8'h02), 14);
        chk("lp_done_idx", done_idx, 53);
        chk("lp_done_cnt", done_cnt, 1);
        wait_idle();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
